// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the TCM SRAM request controller.
//   - access size encodings (SZ_B / SZ_H / SZ_W, SZ_X illegal)
//   - controller FSM state constants and enum
//   - load context carried from accept into the data-return cycle
//   - lane_mask(): byte-lane write mask for a given size/offset
package sram_ctrl_pkg;

  typedef logic [1:0] sz_t;
  localparam sz_t SZ_B = 2'b00;
  localparam sz_t SZ_H = 2'b01;
  localparam sz_t SZ_W = 2'b10;
  localparam sz_t SZ_X = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RD   = ST_RD,
    RESP = ST_RESP
  } state_e;

  // What the data-return cycle needs to pick and extend the right lane.
  typedef struct packed {
    logic [1:0] off;
    sz_t        size;
    logic       uns;
  } ld_ctx_t;

  function automatic logic [3:0] lane_mask(input sz_t size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << off;
      SZ_H:    lane_mask = 4'b0011 << {off[1], 1'b0};
      SZ_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/tcm_load_align.sv
// Load data alignment: picks the addressed byte/half out of an SRAM word
// and sign- or zero-extends it to 32 bits.
//   word : raw SRAM read word
//   off  : byte offset within the word (addr[1:0])
//   size : access size (SZ_B / SZ_H / SZ_W)
//   uns  : 1 = zero-extend, 0 = sign-extend
//   data : extended, LSB-justified result
module tcm_load_align
  import sram_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  sz_t         size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    data = {{24{~uns & b[7]}}, b};
      SZ_H:    data = {{16{~uns & h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Request-side controller for the single-port TCM SRAM.
// Accepts one load/store at a time, checks size/alignment/range, drives the
// SRAM pins and returns extended load data or a store ack.
//   clk, rst           : clock, async active-high reset
//   req_*              : valid/ready request channel (addr, write, size, unsigned, wdata)
//   rsp_*              : valid/ready response channel (rdata, err)
//   ram_addr/din/we/wem: SRAM word address, write data, write enable, byte mask
//   ram_dout           : SRAM read data, one cycle after the address edge
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int              AW     = 32,
  parameter int              DP     = 512,
  parameter int              RAM_AW = 32,
  parameter logic [AW-1:0]   BASE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  output logic [3:0]        ram_wem,
  input  logic [31:0]       ram_dout
);

  // Two extra bits so the byte limit never overflows the compare.
  localparam logic [AW+1:0] LIM = (AW+2)'(4 * DP);

  state_e            state;
  ld_ctx_t           ctx;
  logic              accept, err, legal_st;
  logic [AW-1:0]     off;
  logic [RAM_AW-1:0] idx, addr_q;
  logic [31:0]       rdata_q, ld_data;
  logic              err_q;

  // Held off during reset so nothing reaches the SRAM pins.
  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign off       = req_addr - BASE;
  assign idx       = RAM_AW'(off >> 2);

  always_comb begin
    case (req_size)
      SZ_H:    err = req_addr[0];
      SZ_W:    err = |req_addr[1:0];
      SZ_X:    err = 1'b1;
      default: err = 1'b0;
    endcase
    if (req_addr < BASE || {2'b00, off} >= LIM) err = 1'b1;
  end

  assign legal_st = accept & req_write & ~err;
  assign ram_we   = legal_st;
  assign ram_wem  = legal_st ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;

  always_comb begin
    ram_din = '0;
    if (legal_st) begin
      case (req_size)
        SZ_B:    ram_din = {4{req_wdata[7:0]}};
        SZ_H:    ram_din = {2{req_wdata[15:0]}};
        default: ram_din = req_wdata;
      endcase
    end
  end

  // Only legal accesses move the SRAM address; it parks otherwise.
  assign ram_addr = (accept & ~err) ? idx : addr_q;

  tcm_load_align u_align (
    .word (ram_dout),
    .off  (ctx.off),
    .size (ctx.size),
    .uns  (ctx.uns),
    .data (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      ctx     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (!err) addr_q <= idx;
          rdata_q <= '0;
          err_q   <= err;
          ctx     <= '{off: req_addr[1:0], size: req_size, uns: req_unsigned};
          state   <= (err | req_write) ? RESP : RD;
        end
        RD: begin
          rdata_q <= ld_data;
          state   <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
